vertex_line_packer: RTL and testbench
=====================================

// Module: vertex_line_packer
// PURPOSE
//  Upstream fill stage for the BFS 64-bank vertex-property BRAM (64 banks x 8 bit, one 512-bit line per address).
//  Accepts a stream of IN_W-bit beats from the DRAM read path and packs 512/IN_W beats into one 512-bit line.
//  Writes num_lines consecutive lines starting at base_addr, one per BRAM write port cycle.
//  Byte i of a line lands in bank i.
//  Sustains full throughput: one beat accepted every cycle while filling.
// PARAMETERS
//  IN_W    64  input beat width in bits. Must be 8, 16, 32, 64, 128, 256 or 512. BEATS = 512/IN_W.
//  ADDR_W  10  BRAM line-address width. DEPTH = 2**ADDR_W lines.
// PORTS
//  clk        in   1         clock; all logic rising-edge
//  rst_n      in   1         reset, asynchronous assert, active-low
//  start      in   1         1-cycle pulse: begin a load (sampled in IDLE only)
//  base_addr  in   ADDR_W    first line address, sampled on start
//  num_lines  in   ADDR_W+1  lines to load, 0..DEPTH, sampled on start
//  in_data    in   IN_W      input beat
//  in_valid   in   1         in_data valid
//  in_ready   out  1         beat accepted when in_valid & in_ready
//  line_data  out  512       line to BRAM write port
//  w_addr     out  ADDR_W    BRAM write address
//  we_out     out  1         BRAM write enable, 1-cycle pulse per line
//  en_out     out  1         BRAM enable; equals we_out
//  busy       out  1         high from start until done
//  done       out  1         1-cycle pulse after the last line write
// BEHAVIOUR
//  Reset values: in_ready=0, line_data=0, w_addr=0, we_out=0, en_out=0, busy=0, done=0.
//  Reset clears the beat counter, line counter and assembly register.
//  FSM states:
//   - IDLE: start with num_lines>0 -> FILL, busy=1.
//           start with num_lines=0 -> FLUSH, so done pulses 2 cycles after start with no write.
//   - FILL: in_ready=1. Beat k (0..BEATS-1) is written to asm[k*IN_W +: IN_W].
//           The beat counter wraps after BEATS-1.
//           On acceptance of the last beat of a line:
//             * next cycle: line_data = assembled line, w_addr = current address, we_out=en_out=1 for exactly that cycle;
//             * the address increments mod 2**ADDR_W, so it wraps DEPTH-1 -> 0;
//             * filling of the next line continues in the same cycle.
//           Back-to-back lines therefore see no bubble.
//           After accepting the last beat of line num_lines: go to FLUSH, in_ready=0.
//   - FLUSH: hold 1 cycle while the final we_out pulse issues. Then done=1 for 1 cycle, busy=0, return to IDLE.
//  Latency: last beat of a line accepted at cycle t -> we_out at t+1.
//           Done is at t+2 for the final line.
//  in_valid=0 stalls the beat counter; no timeout.
//  in_data beats offered while in_ready=0 are ignored.
//  start while busy is ignored; base_addr and num_lines are not re-sampled.
//  line_data and w_addr hold their last values between writes. Downstream must qualify them with we_out.
//  Reset mid-load: the partial line is discarded and no write is issued. The FSM starts at IDLE after rst_n deasserts.
// CONFIGURATION
//  PACKER_ENDIAN_SWAP_EN:
//   - defined: the byte order within each beat is reversed before packing (big-endian DRAM images).
//     in_data[7:0] goes to the highest byte of the beat slot.
//   - undefined: beats are packed as-is; in_data[7:0] of beat 0 goes to bank 0.
//   - It has no effect on timing or on any other port.
// TESTING
//  All scenarios use IN_W=64, ADDR_W=10, macro undefined unless stated.
//  T1 Single line:
//     start, base_addr=5, num_lines=1; beats 0..7 = 64'h0706050403020100 + k*64'h0808080808080808, in_valid always high.
//     -> one we_out, w_addr=5, line_data[7:0]=8'h00, line_data[511:504]=8'h3F.
//     -> done 2 cycles after the last beat; in_ready=0 afterwards.
//  T2 Streaming:
//     num_lines=4, base_addr=0, in_valid=1 for 32 cycles.
//     -> in_ready never drops; we_out in cycles 9, 17, 25, 33 after start accept with w_addr 0..3.
//  T3 Stalls:
//     random in_valid gaps.
//     -> line contents and addresses identical to T2; we_out count=4; no write before each 8th accepted beat.
//  T4 Wrap and zero:
//     base_addr=1023, num_lines=2 -> writes to 1023 then 0.
//     num_lines=0 -> done with no we_out.
//  T5 Reset mid-op:
//     rst_n low after 3 beats of line 0 -> all outputs 0 immediately, no we_out.
//     A new start then loads a clean line.
//  T6 Swap (PACKER_ENDIAN_SWAP_EN defined):
//     beat 0 = 64'h0001020304050607 -> line_data[63:0] = 64'h0706050403020100.

Source files
------------

// File: rtl/vertex_line_packer.sv
// vertex_line_packer: packs IN_W-bit DRAM beats into 512-bit BRAM lines
// and writes num_lines consecutive lines starting at base_addr.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 load pulse (IDLE only)
//   base_addr, num_lines  load setup, sampled on start
//   in_data, in_valid     beat stream in
//   in_ready              beat accepted when in_valid & in_ready
//   line_data, w_addr     BRAM write data and line address
//   we_out, en_out        BRAM write/enable pulse, one per line
//   busy, done            load in progress / 1-cycle completion pulse
//
// Optional build macro PACKER_ENDIAN_SWAP_EN: reverse the byte order
// of each beat before packing (big-endian DRAM images).

module vertex_line_packer #(
  parameter int IN_W   = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_lines,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [511:0]      line_data,
  output logic [ADDR_W-1:0] w_addr,
  output logic              we_out,
  output logic              en_out,
  output logic              busy,
  output logic              done
);

  localparam int BEATS = 512 / IN_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BW-1:0]     beat_q;
  logic [ADDR_W:0]   left_q;
  logic [ADDR_W-1:0] addr_q;
  logic [511:0]      asm_q;
  logic [511:0]      asm_d;
  logic [IN_W-1:0]   beat_data;
  logic              accept;
  logic              last_beat;
  logic              last_line;

  assign accept    = in_valid & in_ready;
  assign last_beat = (beat_q == LAST);
  assign last_line = (left_q == (ADDR_W+1)'(1));

`ifdef PACKER_ENDIAN_SWAP_EN
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < IN_W/8; i++) begin
      beat_data[i*8 +: 8] = in_data[IN_W-8-i*8 +: 8];
    end
  end
`else
  assign beat_data = in_data;
`endif

  // Line including the beat being accepted this cycle, so the final
  // beat goes straight to line_data without an extra stage.
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BW'(k)) begin
        asm_d[k*IN_W +: IN_W] = beat_data;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_lines == '0) ? FLUSH : FILL;
        end
      end
      FILL: begin
        if (accept && last_beat && last_line) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      FLUSH: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  assign en_out = we_out;

  // Datapath: counters, assembly, write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q    <= '0;
      left_q    <= '0;
      addr_q    <= '0;
      asm_q     <= '0;
      line_data <= '0;
      w_addr    <= '0;
      we_out    <= 1'b0;
      done      <= 1'b0;
    end else begin
      we_out <= 1'b0;
      done   <= (state_q == FLUSH);
      if (state_q == IDLE && start) begin
        addr_q <= base_addr;
        left_q <= num_lines;
        beat_q <= '0;
      end
      if (accept) begin
        asm_q  <= asm_d;
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
        if (last_beat) begin
          line_data <= asm_d;
          w_addr    <= addr_q;
          we_out    <= 1'b1;
          addr_q    <= addr_q + 1'b1;
          left_q    <= left_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vertex_line_packer.sv
// tb_vertex_line_packer: table-driven loads with a write scoreboard,
// plus hand-written reset-mid-load sequence.

module tb_vertex_line_packer;

  localparam int IN_W  = 64;
  localparam int AW    = 10;
  localparam int BEATS = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_lines = '0;
  logic [63:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [511:0]  line_data;
  logic [AW-1:0] w_addr;
  logic          we_out;
  logic          en_out;
  logic          busy;
  logic          done;

  vertex_line_packer #(
    .IN_W   (IN_W),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_lines (num_lines),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .line_data (line_data),
    .w_addr    (w_addr),
    .we_out    (we_out),
    .en_out    (en_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  int nwr = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [511:0]  d;
    int            c;
  } wr_t;

  wr_t sb[$];
  wr_t e;

  logic [AW-1:0] last_a;
  logic [511:0]  last_d;
  bit            have_last = 0;

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    int            stall;
    bit            poke;
    int            exp_wr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input int l, input int k);
    return 64'h0706050403020100
         + 64'(l*8 + k) * 64'h0808080808080808;
  endfunction

  function automatic logic [63:0] model_slot(input logic [63:0] b);
    logic [63:0] r;
`ifdef PACKER_ENDIAN_SWAP_EN
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = b[56-i*8 +: 8];
`else
    r = b;
`endif
    return r;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst_n && we_out) begin
      nwr++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: got w_addr=%0d want no write",
                 w_addr);
      end else begin
        e = sb.pop_front();
        chk("w_addr", w_addr, e.a);
        chk("line_data", line_data, e.d);
        chk("we_cycle", cyc, e.c);
        chk("en_out", en_out, 1);
      end
    end
  end

  task automatic run_load(input logic [AW-1:0] b, input int n,
                          input int stall, input bit poke,
                          input int exp_wr);
    int w0;
    int s_cyc;
    int acc_cyc;
    int cycles;
    int budget;
    int k;
    int l;
    int w;
    logic [511:0] ln;
    w0 = nwr;
    cycles = 0;
    k = 0;
    l = 0;
    ln = '0;
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    num_lines = (AW+1)'(n);
    s_cyc = cyc;
    acc_cyc = s_cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    budget = n * BEATS * 8 + 50;
    while (l < n) begin
      if (cycles > budget) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout: got %0d lines want %0d", l, n);
        break;
      end
      cycles++;
      in_valid = (stall == 0) || ($urandom_range(99) >= stall);
      start = poke && (l == 0) && (k == 3);
      base_addr = start ? AW'(77) : b;
      num_lines = start ? (AW+1)'(9) : (AW+1)'(n);
      in_data = in_valid ? beat_val(l, k) : {$urandom, $urandom};
      if (in_valid && in_ready) begin
        ln[k*64 +: 64] = model_slot(beat_val(l, k));
        acc_cyc = cyc;
        k++;
        if (k == BEATS) begin
          sb.push_back('{a: b + AW'(l), d: ln, c: cyc + 1});
          last_a = b + AW'(l);
          last_d = ln;
          have_last = 1;
          k = 0;
          l++;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (stall == 0 && n > 0) chk("no_bubble", cycles, n * BEATS);
    w = 0;
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", done, 1);
    chk("done_cycle", cyc, acc_cyc + 2);
    chk("busy_at_done", busy, 0);
    chk("in_ready_at_done", in_ready, 0);
    // Beats offered while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = {$urandom, $urandom};
      @(negedge clk);
      if (i == 0) chk("done_one_cycle", done, 0);
    end
    in_valid = 1'b0;
    chk("write_count", nwr - w0, exp_wr);
    if (have_last) begin
      chk("hold_w_addr", w_addr, last_a);
      chk("hold_line_data", line_data, last_d);
    end
  endtask

  logic [7:0] exp_lo;
  logic [7:0] exp_hi;

  initial begin
    vecs[0] = '{base: 10'd5,    n: 1, stall: 0,  poke: 0, exp_wr: 1};
    vecs[1] = '{base: 10'd0,    n: 4, stall: 0,  poke: 0, exp_wr: 4};
    vecs[2] = '{base: 10'd0,    n: 4, stall: 40, poke: 1, exp_wr: 4};
    vecs[3] = '{base: 10'd1023, n: 2, stall: 0,  poke: 0, exp_wr: 2};
    vecs[4] = '{base: 10'd0,    n: 0, stall: 0,  poke: 0, exp_wr: 0};
    vecs[5] = '{base: 10'd1020, n: 6, stall: 25, poke: 0, exp_wr: 6};

`ifdef PACKER_ENDIAN_SWAP_EN
    exp_lo = 8'h07;
    exp_hi = 8'h38;
`else
    exp_lo = 8'h00;
    exp_hi = 8'h3F;
`endif

    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_line_data", line_data, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_we_out", we_out, 0);
    chk("rst_en_out", en_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_load(vecs[v].base, vecs[v].n, vecs[v].stall,
               vecs[v].poke, vecs[v].exp_wr);
      if (v == 0) begin
        chk("t1_w_addr", w_addr, 5);
        chk("t1_byte0", line_data[7:0], exp_lo);
        chk("t1_byte63", line_data[511:504], exp_hi);
      end
    end

    // Reset in the middle of line 0.
    begin
      int w0;
      w0 = nwr;
      @(negedge clk);
      start = 1'b1;
      base_addr = 10'd9;
      num_lines = 11'd1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1;
        in_data = 64'hDEAD_BEEF_0000_0000 | 64'(k);
        @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_line_data", line_data, 0);
      chk("mid_rst_w_addr", w_addr, 0);
      chk("mid_rst_we_out", we_out, 0);
      chk("mid_rst_en_out", en_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rst_no_write", nwr - w0, 0);
      chk("mid_rst_idle", busy, 0);
      have_last = 0;
      run_load(10'd9, 1, 0, 0, 1);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
